// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam logic SYNC_RESET = 1'b1;
    localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchroniser, start/data/stop FSM, one-cycle byte/error strobes.
// Define UART_LOADER_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       i_clear,
    input  logic       i_rx_serial,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output rx_state_e  o_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;
    logic             w_rx;
    logic             w_fall;
    logic             w_par_ok;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sync1   <= SYNC_RESET;
            r_sync2   <= SYNC_RESET;
            r_rx_prev <= SYNC_RESET;
        end else begin
            r_sync1   <= i_rx_serial;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;

`ifdef UART_LOADER_PARITY_EN
    logic r_par_bad;
    assign w_par_ok = ~r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (i_clear) begin
                r_state   <= RX_IDLE;
                r_cnt     <= '0;
                r_bit_idx <= '0;
                r_shift   <= '0;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        if (w_fall) begin
                            r_state <= RX_START;
                            r_cnt   <= '0;
                        end
                    end
                    // A start bit that is high again at mid-bit is a glitch, not an error.
                    RX_START: begin
                        if (r_cnt == HALF_LAST) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= w_rx ? RX_IDLE : RX_DATA;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (r_cnt == BIT_LAST) begin
                            r_cnt   <= '0;
                            r_shift <= {w_rx, r_shift[7:1]};
                            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_LOADER_PARITY_EN
                                r_state <= RX_PARITY;
`else
                                r_state <= RX_STOP;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
`ifdef UART_LOADER_PARITY_EN
                    RX_PARITY: begin
                        if (r_cnt == BIT_LAST) begin
                            r_cnt     <= '0;
                            r_par_bad <= (w_rx != ^r_shift);
                            r_state   <= RX_STOP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
`endif
                    // Parity failures are reported on the same strobe as framing errors.
                    RX_STOP: begin
                        if (r_cnt == BIT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= RX_IDLE;
                            if (w_rx && w_par_ok) begin
                                r_byte_valid <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_shift;
    assign o_frame_err  = r_frame_err;
    assign o_state      = r_state;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles received bytes little-endian into words and writes them to memory.
// Optional even parity on the serial line is enabled by defining UART_LOADER_PARITY_EN.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_W       = 12,
    parameter logic [8*WORD_BYTES-1:0] END_WORD = '1
) (
    input  logic                    clock,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    rx_serial,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W:0]         word_count
);

    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    logic              w_byte_valid;
    logic [7:0]        w_byte_data;
    logic              w_frame_err;
    rx_state_e         w_state;
    logic [W-1:0]      w_word;
    logic              w_byte_ok;
    logic              w_word_done;
    logic              w_xfer;
    logic [ADDR_W:0]   w_count_next;

    logic [IDX_W-1:0]  r_byte_idx;
    logic [W-1:0]      r_asm;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [W-1:0]      r_mem_wdata;
    logic [ADDR_W:0]   r_word_count;
    logic              r_done;
    logic              r_err;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock        (clock),
        .resetb       (resetb),
        .i_clear      (~enable),
        .i_rx_serial  (rx_serial),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err),
        .o_state      (w_state)
    );

    always_comb begin
        w_word = r_asm;
        w_word[8*r_byte_idx +: 8] = w_byte_data;
    end

    // Write handshake: mem_we is valid, mem_ready is ready; a word moves on a cycle where both are
    // high. addr/data are held until then, and a transfer frees the buffer for a same-cycle word.
    assign w_xfer       = r_mem_we & mem_ready;
    assign w_byte_ok    = w_byte_valid & ~r_done;
    assign w_word_done  = w_byte_ok & (r_byte_idx == IDX_LAST);
    assign w_count_next = r_word_count + (ADDR_W + 1)'(w_xfer);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else if (!enable) begin
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // The address holds at the top entry once memory is full instead of wrapping.
            if (w_xfer) begin
                r_mem_we     <= 1'b0;
                r_word_count <= w_count_next;
                if (r_mem_addr != '1) begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                end
            end
            if (w_byte_ok) begin
                r_asm[8*r_byte_idx +: 8] <= w_byte_data;
                r_byte_idx <= (r_byte_idx == IDX_LAST) ? '0 : r_byte_idx + IDX_W'(1);
            end
            if (w_word_done) begin
                if (w_word == END_WORD) begin
                    r_done <= 1'b1;
                end else if ((w_count_next == CAPACITY) || (r_mem_we && !w_xfer)) begin
                    r_err <= 1'b1;
                end else begin
                    r_mem_we    <= 1'b1;
                    r_mem_wdata <= w_word;
                end
            end
            if (w_frame_err && !r_done) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_word_count;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = enable & ~r_done & ((w_state != RX_IDLE) | (r_byte_idx != '0) | r_mem_we);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: serial driver, write scoreboard, word-level reference model.
module tb_uart_prog_loader;

    localparam int CPB = 4;
    localparam int WB  = 4;
    localparam int AW  = 3;
    localparam int W   = 8 * WB;
    localparam int CAP = 1 << AW;
    localparam logic [W-1:0] END_W = '1;

    logic          clock = 1'b0;
    logic          resetb = 1'b0;
    logic          enable = 1'b0;
    logic          rx_serial = 1'b1;
    logic          mem_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected writes, {addr, data}, in order.
    logic [AW+W-1:0] exp_q[$];
    int m_count;
    bit m_done;

    always #5 clock = ~clock;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .WORD_BYTES   (WB),
        .ADDR_W       (AW)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .rx_serial  (rx_serial),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (resetb && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
            end else begin
                logic [AW+W-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", {61'd0, mem_addr}, {61'd0, e[AW+W-1:W]});
                check("write_data", {32'd0, mem_wdata}, {32'd0, e[W-1:0]});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_serial = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_LOADER_PARITY_EN
        send_bit(^b);
`endif
        send_bit(!bad_stop);
        rx_serial = 1'b1;
    endtask

    task automatic send_raw_word(input logic [W-1:0] w);
        for (int k = 0; k < WB; k++) send_byte(w[8*k +: 8], 1'b0);
    endtask

    // Reference model: what a completed word should do to memory.
    task automatic model_word(input logic [W-1:0] w);
        if (m_done) return;
        if (w == END_W) m_done = 1;
        else if (m_count < CAP) begin
            exp_q.push_back({AW'(m_count), w});
            m_count++;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_raw_word(w);
        model_word(w);
    endtask

    task automatic reset_model();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        m_count = 0;
        m_done  = 0;
    endtask

    task automatic clear_dut();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2);
        reset_model();
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        do w = $urandom; while (w == END_W || w == '0);
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] wa, wb;
        m_count = 0;
        m_done  = 0;
        tick(3);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_word_count", word_count, 0);
        resetb = 1'b1;
        enable = 1'b1;
        mem_ready = 1'b1;
        tick(4);

        // Little-endian assembly of one word.
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        check("busy_mid_word", busy, 1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        model_word(32'h12345678);
        tick(6);
        check("t1_word_count", word_count, 1);
        check("t1_err", err, 0);
        check("t1_mem_we_low", mem_we, 0);

        // Two words then terminator; done latency and post-done silence.
        clear_dut();
        send_word(32'h1);
        send_word(32'h2);
        send_word(END_W);
        tick(1);
        check("t2_done_not_yet", done, 0);
        tick(1);
        check("t2_done", done, 1);
        tick(4);
        check("t2_busy", busy, 0);
        check("t2_word_count", word_count, 2);
        check("t2_err", err, 0);
        send_word(rand_word());
        tick(4);
        check("t2_ignored_after_done", word_count, 2);

        // Back-pressure: pending write holds, second word overflows.
        clear_dut();
        mem_ready = 1'b0;
        wa = rand_word();
        wb = rand_word();
        send_raw_word(wa);
        tick(3);
        check("t3_pending_we", mem_we, 1);
        check("t3_pending_addr", mem_addr, 0);
        check("t3_pending_data", mem_wdata, wa);
        check("t3_no_err_yet", err, 0);
        send_raw_word(wb);
        tick(3);
        check("t3_overflow_err", err, 1);
        check("t3_held_we", mem_we, 1);
        check("t3_held_addr", mem_addr, 0);
        check("t3_held_data", mem_wdata, wa);
        exp_q.push_back({AW'(0), wa});
        mem_ready = 1'b1;
        tick(3);
        check("t3_word_count", word_count, 1);
        check("t3_we_dropped", mem_we, 0);

        // Framing error discards a byte; following bytes still assemble.
        clear_dut();
        send_byte(8'hA5, 1'b1);
        tick(CPB);
        check("t4_frame_err", err, 1);
        check("t4_busy_idle", busy, 0);
        send_word(rand_word());
        tick(6);
        check("t4_word_count", word_count, 1);

        // Glitch, then reset mid-write and mid-frame.
        clear_dut();
        rx_serial = 1'b0;
        tick(1);
        rx_serial = 1'b1;
        tick(10);
        check("t5_glitch_err", err, 0);
        check("t5_glitch_busy", busy, 0);
        mem_ready = 1'b0;
        send_raw_word(rand_word());
        tick(3);
        check("t5_pending_before_rst", mem_we, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        resetb = 1'b0;
        tick(1);
        check("t5_rst_mem_we", mem_we, 0);
        check("t5_rst_mem_addr", mem_addr, 0);
        check("t5_rst_mem_wdata", mem_wdata, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_err", err, 0);
        check("t5_rst_word_count", word_count, 0);
        rx_serial = 1'b1;
        tick(CPB);
        resetb = 1'b1;
        mem_ready = 1'b1;
        tick(CPB);
        reset_model();
        send_word(rand_word());
        tick(6);
        check("t5_fresh_word", word_count, 1);

        // Capacity: ninth word is dropped; terminator still accepted.
        clear_dut();
        for (int i = 0; i < CAP + 1; i++) send_word(rand_word());
        tick(6);
        check("t6_word_count", word_count, CAP);
        check("t6_err", err, 1);
        send_word(END_W);
        tick(4);
        check("t6_done", done, 1);
        check("t6_count_saturated", word_count, CAP);

`ifdef UART_LOADER_PARITY_EN
        // Bad parity bit discards the byte.
        clear_dut();
        begin
            logic [7:0] b;
            b = 8'($urandom);
            send_bit(1'b0);
            for (int i = 0; i < 8; i++) send_bit(b[i]);
            send_bit(~(^b));
            send_bit(1'b1);
        end
        tick(CPB);
        check("t7_parity_err", err, 1);
        check("t7_parity_busy", busy, 0);
        send_word(rand_word());
        tick(6);
        check("t7_word_after_parity", word_count, 1);
`endif

        tick(4);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Parametrised UART program loader for the user project area. It receives a serial byte stream on an `mprj_io` pin once the management core signals readiness, and assembles bytes little-endian into words of configurable width. Each word is written sequentially into a user-side instruction/data memory through a ready/valid write port. A configurable terminator word ends the load and raises `done`. It generalises the fixed-width 32-bit, fixed-baud program-over-UART flow into a synthesizable block with width, depth, baud, error reporting and optional parity.

## Interface
- `CLKS_PER_BIT`, 347: clock cycles per UART bit (40 MHz / 115200); must be ≥ 4.
- `WORD_BYTES`, 4: bytes per memory word; word width `W = 8*WORD_BYTES`.
- `ADDR_W`, 12: memory word-address width; capacity `2**ADDR_W` words.
- `END_WORD`, all-ones of width W: terminator value; never written to memory.

Ports:
- `clock`  in  1  system clock.
- `resetb`  in  1  asynchronous, active-low reset.
- `enable`  in  1  loader armed; low holds the block in its cleared state.
- `rx_serial`  in  1  UART line, idle high, 8 data bits LSB first, 1 stop bit.
- `mem_we`  out  1  write request (valid).
- `mem_addr`  out  ADDR_W  word address of the pending write.
- `mem_wdata`  out  W  word data of the pending write.
- `mem_ready`  in  1  memory accepts; transfer occurs when `mem_we && mem_ready`.
- `busy`  out  1  reception or write in progress.
- `done`  out  1  sticky; terminator received.
- `err`  out  1  sticky; framing, parity, overflow or capacity error.
- `word_count`  out  ADDR_W+1  words written so far.

## Operation
- `rx_serial` passes through a 2-flop synchroniser, which resets to 1.
- RX FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE: a synchronised falling edge enters START.
- START: waits `CLKS_PER_BIT/2` (floor) cycles, then samples. Low → DATA. High → glitch, return to IDLE with no error.
- DATA: samples 8 bits, one every `CLKS_PER_BIT` cycles, LSB first.
- STOP: samples the stop bit one bit period later. 1 → byte valid. 0 → framing error: byte discarded, `err` set, FSM returns to IDLE.
- Assembler: byte k of a word goes to bits `[8k+7:8k]`; the byte index wraps after `WORD_BYTES` bytes.
- When a word completes and equals `END_WORD`: `done` is set, no write occurs, and further RX traffic is ignored until `enable` falls.
- When a word completes and differs from `END_WORD`: it loads the single write buffer and `mem_we` rises.
  - `mem_addr` and `mem_wdata` hold stable until transfer.
  - On transfer, `mem_addr` and `word_count` increment.
- Word completes while a write is still pending: the new word is dropped, `err` is set, and the pending write continues.
- Capacity: once `word_count == 2**ADDR_W`, further non-terminator words are dropped, `err` is set, the address does not wrap and `word_count` saturates. The terminator still sets `done`.
- `enable` low: synchronous clear of the FSM, assembler, buffer, `mem_we`, address, `word_count`, `done` and `err`. A pending write is abandoned.
- `busy = enable & ~done & (FSM≠IDLE | byte index≠0 | mem_we)`.

## Timing
- Reset values: `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `err` 0, `word_count` 0. FSM is in IDLE; synchroniser flops are 1.
- Latency: `mem_we` rises 1 cycle after the clock edge that samples the last byte's stop bit. `done` has the same latency.
- Write with `mem_ready` held high: exactly one cycle of `mem_we`. A back-to-back next word can never arrive sooner than one UART frame later.
- `mem_ready` asserted while `mem_we` is 0 has no effect.
- Simultaneous transfer and word completion in the same cycle: the transfer frees the buffer first, so the new word is accepted without error.
- `resetb` asserted mid-frame or mid-write: all state returns to reset values immediately; the next frame must begin with a fresh start bit.

## Configuration
- `UART_LOADER_PARITY_EN` defined: the PARITY state is inserted after DATA and samples an even-parity bit. A mismatch discards the byte and sets `err`. The frame is 11 bit times.
- `UART_LOADER_PARITY_EN` not defined: no PARITY state, 10-bit frames, no parity checking.

## Structure
- Package `uart_loader_pkg` holds:
  - the RX state enum (IDLE, START, DATA, PARITY, STOP);
  - the synchroniser reset constant;
  - the data-bit count constant (8).
- Sub-module `uart_rx_core` contains the synchroniser, RX FSM and bit counters. It outputs a one-cycle `byte_valid` plus `byte_data`, and a one-cycle `frame_err`.
- The top level contains the assembler, write buffer, address and counter logic, and the flags.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, `WORD_BYTES=4`, `ADDR_W=3`.
- Send bytes 0x78,0x56,0x34,0x12 with `mem_ready`=1 → one `mem_we` pulse, `mem_addr`=0, `mem_wdata`=0x12345678, `word_count`=1.
- Send words 0x1, 0x2, then 0xFFFFFFFF → writes to addresses 0 and 1; `done`=1 one cycle after the terminator's stop-bit sample; `busy`=0; no third write.
- Hold `mem_ready`=0 and send two words → the first stays pending with stable addr/data; the second is dropped and `err`=1; release `mem_ready` → exactly one write, to address 0.
- Send a frame with the stop bit forced 0 → byte discarded, `err`=1; the next 4 good bytes form a word and are written.
- Send a 1-cycle low glitch on `rx_serial` → no byte, `err` stays 0. Pulse `resetb` low mid-frame → all outputs return to 0.
- Send 9 non-terminator words → 8 writes to addresses 0–7, the 9th is dropped, `err`=1, `word_count`=8. With `UART_LOADER_PARITY_EN` defined, a bad parity bit → byte discarded, `err`=1.
